// File: rtl/revelar_celdas.sv
// Minesweeper reveal/flag engine: latches a board, serves player actions and
// flood-expands zero cells with a sequential multi-pass sweep.
module revelar_celdas #(
    parameter int unsigned LADO = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     iniciar,
    input  logic [LADO*LADO-1:0]     minas,
    input  logic [3*LADO*LADO-1:0]   cuentas,
    input  logic [2:0]               cursor_fila,
    input  logic [2:0]               cursor_col,
    input  logic                     btn_revelar,
    input  logic                     btn_bandera,
    output logic [LADO*LADO-1:0]     reveladas,
    output logic [LADO*LADO-1:0]     banderas,
    output logic [6:0]               restantes,
    output logic [2:0]               estado,
    output logic                     ocupado
);

    localparam int unsigned N  = LADO * LADO;
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned RW = 7;

    typedef enum logic [2:0] {
        INACTIVO = 3'd0,
        CARGAR   = 3'd1,
        JUGANDO  = 3'd2,
        EXPANDIR = 3'd3,
        PERDIDO  = 3'd4,
        GANADO   = 3'd5
    } estado_t;

    estado_t             r_estado;
    logic [N-1:0]        r_minas;
    logic [3*N-1:0]      r_cuentas;
    logic [N-1:0]        r_rev;
    logic [N-1:0]        r_ban;
    logic [RW-1:0]       r_rest;
    logic [IW-1:0]       r_scan;
    logic                r_cambio;
    logic                r_ocupado;

    logic [N-1:0]        w_cero;
    logic [N-1:0]        w_izq;
    logic [N-1:0]        w_der;
    logic [N-1:0]        w_cero_rev;
    logic [N-1:0]        w_vecino;
    logic [N-1:0]        w_expandible;
    logic [IW-1:0]       w_sel;
    logic [RW-1:0]       w_rest_dec;
    logic [RW-1:0]       w_rest_carga;
    logic                w_ultimo;
    logic                w_exp_sel;

    // Per-cell zero-count flag and left/right board-edge masks
    for (genvar i = 0; i < N; i++) begin : g_celda
        assign w_cero[i] = (r_cuentas[3*i +: 3] == 3'd0);
        assign w_izq[i]  = ((i % LADO) == 0);
        assign w_der[i]  = ((i % LADO) == (LADO - 1));
    end

    // Cells touching a revealed zero; row overflow falls off the shift ends
    assign w_cero_rev = r_rev & ~r_minas & w_cero;
    assign w_vecino   = (w_cero_rev << LADO) | (w_cero_rev >> LADO)
                      | ((w_cero_rev << 1)          & ~w_izq)
                      | ((w_cero_rev >> 1)          & ~w_der)
                      | ((w_cero_rev << (LADO + 1)) & ~w_izq)
                      | ((w_cero_rev << (LADO - 1)) & ~w_der)
                      | ((w_cero_rev >> (LADO - 1)) & ~w_izq)
                      | ((w_cero_rev >> (LADO + 1)) & ~w_der);
    assign w_expandible = ~r_rev & ~r_ban & ~r_minas & w_vecino;

    assign w_sel        = IW'(cursor_fila) * IW'(LADO) + IW'(cursor_col);
    assign w_rest_dec   = (r_rest != '0) ? r_rest - RW'(1) : r_rest;
    assign w_rest_carga = r_minas[r_scan] ? w_rest_dec : r_rest;
    assign w_ultimo     = (r_scan == IW'(N - 1));
    assign w_exp_sel    = w_expandible[r_scan];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estado  <= INACTIVO;
            r_minas   <= '0;
            r_cuentas <= '0;
            r_rev     <= '0;
            r_ban     <= '0;
            r_rest    <= '0;
            r_scan    <= '0;
            r_cambio  <= 1'b0;
            r_ocupado <= 1'b0;
        end else if (iniciar) begin
            r_estado  <= CARGAR;
            r_minas   <= minas;
            r_cuentas <= cuentas;
            r_rev     <= '0;
            r_ban     <= '0;
            r_rest    <= RW'(N);
            r_scan    <= '0;
            r_cambio  <= 1'b0;
            r_ocupado <= 1'b1;
        end else begin
            case (r_estado)
                CARGAR: begin
                    r_rest <= w_rest_carga;
                    r_scan <= w_ultimo ? '0 : r_scan + IW'(1);
                    if (w_ultimo) begin
                        r_ocupado <= 1'b0;
                        r_estado  <= (w_rest_carga == '0) ? GANADO : JUGANDO;
                    end
                end
                JUGANDO: begin
                    // A reveal press masks a simultaneous flag press
                    if (btn_revelar) begin
                        if (!r_rev[w_sel] && !r_ban[w_sel]) begin
                            r_rev[w_sel] <= 1'b1;
                            if (r_minas[w_sel]) begin
                                r_estado <= PERDIDO;
                            end else begin
                                r_rest <= w_rest_dec;
                                if (w_cero[w_sel]) begin
                                    r_estado  <= EXPANDIR;
                                    r_scan    <= '0;
                                    r_cambio  <= 1'b0;
                                    r_ocupado <= 1'b1;
                                end else if (w_rest_dec == '0) begin
                                    r_estado <= GANADO;
                                end
                            end
                        end
                    end else if (btn_bandera && !r_rev[w_sel]) begin
                        r_ban[w_sel] <= ~r_ban[w_sel];
                    end
                end
                EXPANDIR: begin
                    r_scan <= w_ultimo ? '0 : r_scan + IW'(1);
                    if (w_exp_sel) begin
                        r_rev[r_scan] <= 1'b1;
                        r_rest        <= w_rest_dec;
                    end
                    // Another pass is needed whenever this one revealed anything
                    if (w_ultimo) begin
                        if (r_cambio || w_exp_sel) begin
                            r_cambio <= 1'b0;
                        end else begin
                            r_ocupado <= 1'b0;
                            r_estado  <= (r_rest == '0) ? GANADO : JUGANDO;
                        end
                    end else if (w_exp_sel) begin
                        r_cambio <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign reveladas = r_rev;
    assign banderas  = r_ban;
    assign restantes = r_rest;
    assign estado    = r_estado;
    assign ocupado   = r_ocupado;

endmodule

// File: tb/tb_revelar_celdas.sv
// Scoreboard bench for revelar_celdas: stimulus queues expected snapshots
// tagged with a cycle number, a monitor compares them on the falling edge.
module tb_revelar_celdas;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         iniciar = 1'b0;
    logic [63:0]  minas = '0;
    logic [191:0] cuentas = '0;
    logic [2:0]   cursor_fila = '0;
    logic [2:0]   cursor_col = '0;
    logic         btn_revelar = 1'b0;
    logic         btn_bandera = 1'b0;
    logic [63:0]  reveladas;
    logic [63:0]  banderas;
    logic [6:0]   restantes;
    logic [2:0]   estado;
    logic         ocupado;

    revelar_celdas #(.LADO(8)) dut (
        .clk(clk), .rst(rst), .iniciar(iniciar), .minas(minas), .cuentas(cuentas),
        .cursor_fila(cursor_fila), .cursor_col(cursor_col),
        .btn_revelar(btn_revelar), .btn_bandera(btn_bandera),
        .reveladas(reveladas), .banderas(banderas), .restantes(restantes),
        .estado(estado), .ocupado(ocupado)
    );

    always #5 clk = ~clk;

    int ciclo = 0;
    always @(posedge clk) ciclo++;

    typedef struct {
        string       nombre;
        int          ciclo;
        logic [63:0] rev;
        logic [63:0] ban;
        logic [6:0]  rest;
        logic [2:0]  est;
        logic        ocup;
    } esp_t;

    esp_t q[$];
    esp_t e;
    int   n_cmp = 0;
    int   n_err = 0;

    localparam logic [63:0] M63 = 64'h8000_0000_0000_0000;
    localparam logic [63:0] M18 = 64'h0000_0000_0004_0000;
    localparam logic [63:0] M9  = 64'h0000_0000_0000_0200;

    // Monitor: compare every snapshot whose cycle has arrived
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].ciclo <= ciclo) begin
            e = q.pop_front();
            n_cmp++;
            if (reveladas !== e.rev || banderas !== e.ban || restantes !== e.rest ||
                estado !== e.est || ocupado !== e.ocup) begin
                n_err++;
                $display("FAIL %s @%0d: got rev=%h ban=%h rest=%0d est=%0d ocup=%0b, expected rev=%h ban=%h rest=%0d est=%0d ocup=%0b",
                         e.nombre, ciclo, reveladas, banderas, restantes, estado, ocupado,
                         e.rev, e.ban, e.rest, e.est, e.ocup);
            end
        end
    end

    // Upstream adjacency-count stage model
    function automatic logic [191:0] calc_cuentas(input logic [63:0] m);
        logic [191:0] r;
        int n;
        r = '0;
        for (int f = 0; f < 8; f++) begin
            for (int c = 0; c < 8; c++) begin
                n = 0;
                for (int df = -1; df <= 1; df++)
                    for (int dc = -1; dc <= 1; dc++)
                        if ((df != 0 || dc != 0) && f + df >= 0 && f + df < 8 &&
                            c + dc >= 0 && c + dc < 8)
                            n += int'(m[6'((f + df) * 8 + c + dc)]);
                r[8'(3 * (f * 8 + c)) +: 3] = 3'(n);
            end
        end
        return r;
    endfunction

    task automatic esperar(input string nm, input int d, input logic [63:0] rv,
                           input logic [63:0] bn, input int rs, input int es, input logic oc);
        esp_t x;
        x.nombre = nm; x.ciclo = ciclo + d; x.rev = rv; x.ban = bn;
        x.rest = 7'(rs); x.est = 3'(es); x.ocup = oc;
        q.push_back(x);
    endtask

    task automatic hasta(input int c);
        while (ciclo < c) @(negedge clk);
    endtask

    task automatic cargar(input logic [63:0] m);
        minas = m;
        cuentas = calc_cuentas(m);
        iniciar = 1'b1;
        @(negedge clk);
        iniciar = 1'b0;
    endtask

    task automatic boton(input logic rv, input logic bn, input int f, input int c);
        cursor_fila = 3'(f);
        cursor_col = 3'(c);
        btn_revelar = rv;
        btn_bandera = bn;
        @(negedge clk);
        btn_revelar = 1'b0;
        btn_bandera = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int t0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        esperar("reset", 1, 64'h0, 64'h0, 0, 0, 1'b0);
        @(negedge clk);

        // Single mine at idx 9, load, reveal counted cell (0,1)
        t0 = ciclo;
        esperar("carga_inicio", 1, 64'h0, 64'h0, 64, 1, 1'b1);
        esperar("carga_ultima", 64, 64'h0, 64'h0, 63, 1, 1'b1);
        esperar("carga_fin", 65, 64'h0, 64'h0, 63, 2, 1'b0);
        cargar(M9);
        hasta(t0 + 65);
        esperar("revela_contada", 1, 64'h2, 64'h0, 62, 2, 1'b0);
        boton(1'b1, 1'b0, 0, 1);
        esperar("revela_gana_a_bandera", 1, 64'h3, 64'h0, 61, 2, 1'b0);
        boton(1'b1, 1'b1, 0, 0);
        esperar("bandera_en_revelada", 1, 64'h3, 64'h0, 61, 2, 1'b0);
        boton(1'b0, 1'b1, 0, 1);

        // Reset mid-game, then buttons ignored in INACTIVO
        esperar("reset_medio", 1, 64'h0, 64'h0, 0, 0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        esperar("inactivo_ignora", 1, 64'h0, 64'h0, 0, 0, 1'b0);
        boton(1'b1, 1'b0, 0, 2);

        // Mine at (2,2): flag blocks reveal, unflag, hit mine
        t0 = ciclo;
        esperar("carga_m18", 65, 64'h0, 64'h0, 63, 2, 1'b0);
        cargar(M18);
        hasta(t0 + 65);
        esperar("bandera_22", 1, 64'h0, M18, 63, 2, 1'b0);
        boton(1'b0, 1'b1, 2, 2);
        esperar("revela_con_bandera", 1, 64'h0, M18, 63, 2, 1'b0);
        boton(1'b1, 1'b0, 2, 2);
        esperar("quita_bandera", 1, 64'h0, 64'h0, 63, 2, 1'b0);
        boton(1'b0, 1'b1, 2, 2);
        esperar("mina", 1, M18, 64'h0, 63, 4, 1'b0);
        boton(1'b1, 1'b0, 2, 2);
        esperar("perdido_ignora", 1, M18, 64'h0, 63, 4, 1'b0);
        boton(1'b1, 1'b1, 0, 0);

        // Flood from (0,0) with one mine in the far corner
        t0 = ciclo;
        esperar("carga_m63", 65, 64'h0, 64'h0, 63, 2, 1'b0);
        cargar(M63);
        hasta(t0 + 65);
        t0 = ciclo;
        esperar("expandir_inicio", 1, 64'h1, 64'h0, 62, 3, 1'b1);
        esperar("expandir_pasada1", 65, ~M63, 64'h0, 0, 3, 1'b1);
        esperar("expandir_pasada2", 128, ~M63, 64'h0, 0, 3, 1'b1);
        esperar("expandir_gana", 129, ~M63, 64'h0, 0, 5, 1'b0);
        boton(1'b1, 1'b0, 0, 0);
        hasta(t0 + 129);
        esperar("ganado_ignora", 1, ~M63, 64'h0, 0, 5, 1'b0);
        boton(1'b0, 1'b1, 1, 1);

        // Zero-mine board, flag at (7,7) stops the flood
        t0 = ciclo;
        esperar("carga_vacio", 65, 64'h0, 64'h0, 64, 2, 1'b0);
        cargar(64'h0);
        hasta(t0 + 65);
        esperar("bandera_77", 1, 64'h0, M63, 64, 2, 1'b0);
        boton(1'b0, 1'b1, 7, 7);
        t0 = ciclo;
        esperar("bloqueo_inicio", 1, 64'h1, M63, 63, 3, 1'b1);
        esperar("bloqueo_fin", 129, ~M63, M63, 1, 2, 1'b0);
        boton(1'b1, 1'b0, 0, 0);
        hasta(t0 + 129);

        // iniciar aborts an expansion and the new board is used
        t0 = ciclo;
        esperar("carga_vacio2", 65, 64'h0, 64'h0, 64, 2, 1'b0);
        cargar(64'h0);
        hasta(t0 + 65);
        t0 = ciclo;
        esperar("expandir_previo", 1, 64'h1, 64'h0, 63, 3, 1'b1);
        boton(1'b1, 1'b0, 0, 0);
        hasta(t0 + 10);
        t0 = ciclo;
        esperar("aborta_expandir", 1, 64'h0, 64'h0, 64, 1, 1'b1);
        esperar("carga_m0", 65, 64'h0, 64'h0, 63, 2, 1'b0);
        cargar(64'h1);
        hasta(t0 + 65);
        esperar("mina_nuevo_tablero", 1, 64'h1, 64'h0, 63, 4, 1'b0);
        boton(1'b1, 1'b0, 0, 0);

        // All-mine board: nothing safe, straight to GANADO
        t0 = ciclo;
        esperar("todas_ultima", 64, 64'h0, 64'h0, 1, 1, 1'b1);
        esperar("todas_gana", 65, 64'h0, 64'h0, 0, 5, 1'b0);
        cargar('1);
        hasta(t0 + 65);
        esperar("todas_ignora", 1, 64'h0, 64'h0, 0, 5, 1'b0);
        boton(1'b1, 1'b0, 3, 3);

        repeat (5) if (q.size() > 0) @(negedge clk);
        if (q.size() > 0) begin
            n_err++;
            $display("FAIL drenaje: got %0d pending snapshots, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/revelar_celdas.md
Name: revelar_celdas

Overview:
- Downstream consumer of the mine-placement / adjacency-count stage in the minesweeper lab.
- Latches the mine map and per-cell adjacency counts on game start, then handles player reveal/flag actions.
- Performs zero-cell flood expansion with a sequential sweep FSM.
- Reports revealed/flagged masks and the game state (playing, lost, won) to the display/VGA stage.

Parameters:
LADO, 8, board side length; cells = LADO*LADO; cell index idx = fila*LADO + col.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-high reset.
iniciar  in  1  one-cycle pulse; latch board and start a new game.
minas  in  LADO*LADO  mine map; bit idx = 1 means mine.
cuentas  in  3*LADO*LADO  adjacent-mine counts; cuentas[3*idx +: 3] belongs to cell idx.
cursor_fila  in  3  selected row.
cursor_col  in  3  selected column.
btn_revelar  in  1  one-cycle pulse; reveal the selected cell.
btn_bandera  in  1  one-cycle pulse; toggle the flag on the selected cell.
reveladas  out  LADO*LADO  revealed-cell mask.
banderas  out  LADO*LADO  flagged-cell mask.
restantes  out  7  safe cells still hidden.
estado  out  3  game state: 0 INACTIVO, 1 CARGAR, 2 JUGANDO, 3 EXPANDIR, 4 PERDIDO, 5 GANADO.
ocupado  out  1  high in CARGAR and EXPANDIR; buttons are ignored while high.

Behaviour:
- Reset (async, active-high): reveladas=0, banderas=0, restantes=0, estado=INACTIVO, ocupado=0, internal board registers=0.
- iniciar has the highest priority and is honoured in every state:
  - Next cycle: latch minas and cuentas internally, clear reveladas and banderas, set restantes=64, scan index=0, estado=CARGAR.
  - Inputs minas and cuentas are not sampled after this latch.
- CARGAR:
  - One cell per cycle, idx 0..63; restantes decrements for each latched mine.
  - After idx 63 (64 cycles): if restantes==0 go GANADO, else JUGANDO.
- JUGANDO: on btn_revelar, the cell at (cursor_fila, cursor_col):
  - Flagged or already revealed: ignored.
  - Mine: reveal bit set, estado=PERDIDO; both visible the next cycle.
  - Safe: reveal bit set and restantes-1 next cycle; then:
    - cuenta==0: go to EXPANDIR with scan index=0.
    - cuenta!=0 and new restantes==0: go GANADO.
    - Otherwise: stay JUGANDO.
- JUGANDO: on btn_bandera, toggle banderas[idx] only if the cell is not revealed; the toggle is visible the next cycle.
- btn_revelar and btn_bandera in the same cycle: reveal wins, flag is ignored.
- EXPANDIR:
  - One cell per cycle, idx 0..63, in passes.
  - Reveal cell i iff all of the following hold:
    - i is not revealed, not flagged and not a mine;
    - some in-bounds 8-neighbour n is revealed, not a mine and has cuenta[n]==0.
  - Each such reveal decrements restantes and sets a pass-changed flag.
  - Edge cells ignore out-of-range neighbours; there is no wrap-around.
  - At the end of a pass (idx 63):
    - Changed: clear the flag and restart at idx 0.
    - Unchanged: go GANADO if restantes==0, else JUGANDO.
  - Minimum duration is 64 cycles; worst case is 64*passes.
- PERDIDO and GANADO are terminal: buttons are ignored; only iniciar or rst leaves them.
- INACTIVO: buttons are ignored.
- restantes never underflows; a mine reveal never changes it.
- Reset mid-EXPANDIR: all state is cleared immediately, with no partial pass retained.

Test Plan:
- Reset check: rst pulse mid-game -> all outputs 0, estado=INACTIVO on the same cycle; btn_revelar then ignored.
- Load, then reveal a counted cell:
  - Stimulus: minas with a single mine at idx 9, iniciar.
  - After 1+64 cycles: estado=JUGANDO, restantes=63.
  - Then reveal (0,1), cuenta=1: reveladas=bit1 only, restantes=62, estado=JUGANDO.
- Flood expansion:
  - Stimulus: single mine at idx 63, reveal (0,0).
  - Required: estado=EXPANDIR, ocupado=1; finishes with every non-mine cell revealed, restantes=0, estado=GANADO.
- Mine hit: flag (2,2) then reveal (2,2) -> ignored; unflag, reveal mine (2,2) -> reveladas bit 18 set, estado=PERDIDO; later buttons ignored.
- Flag blocks expansion:
  - Stimulus: zero-mine board, flag (7,7), reveal (0,0).
  - Required: 63 cells revealed, bit 63 not revealed, restantes=1, estado=JUGANDO.
- iniciar during EXPANDIR -> sweep aborts, masks cleared, estado=CARGAR next cycle; new board used.
